// File: rtl/wb_reg_bridge_if.sv
// Wishbone classic B4 signal bundle between the interconnect (master) and
// the register-bus bridge (slave).
interface wb_reg_bridge_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_reg_bridge.sv
// Wishbone classic slave driving a simple addr/we/wdata/rdata register bus;
// partial byte-select writes become a read-modify-write of the target word.
module wb_reg_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned NUM_REGS  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_reg_bridge_if.slave       wb,
    output logic [1:0]           reg_addr,
    output logic                 reg_we,
    output logic [31:0]          reg_wdata,
    input  logic [31:0]          reg_rdata
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] ACK  = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    logic [2:0]  state;
    logic        we_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic [31:0] merged;
    logic        bad_addr;

    assign bad_addr = (wb.wb_adr_i[31:4] != BASE_ADDR[31:4])
                   || ({30'd0, wb.wb_adr_i[3:2]} >= NUM_REGS)
                   || (wb.wb_adr_i[1:0] != 2'b00);

    // Selected bytes come from the master, the rest from the current register value.
    always_comb begin
        merged = reg_rdata;
        for (int b = 0; b < 4; b++)
            if (sel_q[b]) merged[8*b +: 8] = dat_q[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wb.wb_dat_o <= '0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            we_q        <= 1'b0;
            dat_q       <= '0;
            sel_q       <= '0;
        end else begin
            case (state)
                IDLE: if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    reg_addr <= wb.wb_adr_i[3:2];
                    we_q     <= wb.wb_we_i;
                    dat_q    <= wb.wb_dat_i;
                    sel_q    <= wb.wb_sel_i;
                    if (bad_addr)
                        state <= ERR;
                    else if (wb.wb_we_i && wb.wb_sel_i == 4'h0)
                        state <= ACK;
                    else if (wb.wb_we_i && wb.wb_sel_i == 4'hF) begin
                        state     <= WR;
                        reg_wdata <= wb.wb_dat_i;
                    end else
                        state <= RD;
                end
                RD: begin
                    // Read data is captured even on an abort edge; only the FSM unwinds.
                    if (we_q) begin
                        reg_wdata <= merged;
                        state     <= WR;
                    end else begin
                        wb.wb_dat_o <= reg_rdata;
                        state       <= ACK;
                    end
                    if (!wb.wb_cyc_i) state <= IDLE;
                end
                WR:       state <= wb.wb_cyc_i ? ACK : IDLE;
                ACK, ERR: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Gated by rst so a reset landing in WR never lets the peripheral write.
    assign reg_we      = (state == WR)  && wb.wb_cyc_i && !rst;
    assign wb.wb_ack_o = (state == ACK) && wb.wb_cyc_i && !rst;
    assign wb.wb_err_o = (state == ERR) && wb.wb_cyc_i && !rst;
endmodule

// File: tb/tb_wb_reg_bridge.sv
// Bench for wb_reg_bridge: directed scenarios plus randomized traffic checked
// against a word-level model of the peripheral register file and bus timing.
module tb_wb_reg_bridge;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          NREG = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  reg_addr;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    wb_reg_bridge_if bus();

    wb_reg_bridge #(.BASE_ADDR(BASE), .NUM_REGS(NREG)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (bus),
        .reg_addr  (reg_addr),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    // Peripheral: four plain word registers, combinational read.
    logic [31:0] periph [4] = '{default: 32'h0};
    always @(posedge clk) if (reg_we) periph[reg_addr] <= reg_wdata;
    assign reg_rdata = periph[reg_addr];

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] exp_regs [4] = '{default: 32'h0};
    logic [31:0] exp_dato = 32'h0;

    // Observations of the last transaction (cycle numbers, -1 = never seen)
    int          r_ack, r_err, r_wecyc, r_wen;
    logic [1:0]  r_wea;
    logic [31:0] r_wed;
    bit          r_both;

    // Called at posedge+1; returns at posedge+1 after the terminating edge.
    task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input bit keep);
        r_ack = -1; r_err = -1; r_wecyc = -1; r_wen = 0; r_wea = '0; r_wed = '0; r_both = 0;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr;  bus.wb_dat_i = dat;  bus.wb_sel_i = sel;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (reg_we) begin r_wen++; r_wecyc = k; r_wea = reg_addr; r_wed = reg_wdata; end
            if (bus.wb_ack_o && bus.wb_err_o) r_both = 1;
            if (bus.wb_ack_o && r_ack < 0) r_ack = k;
            if (bus.wb_err_o && r_err < 0) r_err = k;
            if (bus.wb_ack_o || bus.wb_err_o) break;
        end
        if (!keep) begin bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; end
        @(posedge clk); #1;
    endtask

    // Outcome derived from the address decode and byte-select rules.
    function automatic void model_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                                      input logic [3:0] sel, output int e_ack, output int e_err,
                                      output int e_we, output logic [31:0] e_wdata);
        int idx;
        idx = int'(adr[3:2]);
        e_ack = -1; e_err = -1; e_we = -1; e_wdata = '0;
        if (adr[31:4] != BASE[31:4] || idx >= NREG || adr[1:0] != 2'b00) e_err = 1;
        else if (we && sel == 4'h0) e_ack = 1;
        else if (!we) e_ack = 2;
        else begin
            for (int b = 0; b < 4; b++)
                e_wdata[8*b +: 8] = sel[b] ? dat[8*b +: 8] : exp_regs[idx][8*b +: 8];
            e_we  = (sel == 4'hF) ? 1 : 2;
            e_ack = e_we + 1;
        end
    endfunction

    task automatic test_reset();
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat_o got %h want 0", bus.wb_dat_o); end
        n_chk++; if (reg_addr !== 2'h0) begin n_fail++; $display("FAIL reset_reg_addr got %h want 0", reg_addr); end
        n_chk++; if (reg_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_reg_wdata got %h want 0", reg_wdata); end
        n_chk++; if ({reg_we, bus.wb_ack_o, bus.wb_err_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes got %b want 000", {reg_we, bus.wb_ack_o, bus.wb_err_o}); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_write();
        run_txn(BASE, 1'b1, 32'hFFFF_00FF, 4'hF, 0);
        exp_regs[0] = 32'hFFFF_00FF;
        n_chk++; if (r_wecyc !== 1 || r_wen !== 1) begin n_fail++; $display("FAIL full_wr_we got cyc %0d n %0d want cyc 1 n 1", r_wecyc, r_wen); end
        n_chk++; if (r_wea !== 2'd0 || r_wed !== 32'hFFFF_00FF) begin n_fail++; $display("FAIL full_wr_data got %0d/%h want 0/ffff00ff", r_wea, r_wed); end
        n_chk++; if (r_ack !== 2 || r_err !== -1) begin n_fail++; $display("FAIL full_wr_ack got ack %0d err %0d want 2/-1", r_ack, r_err); end
        n_chk++; if (bus.wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL full_wr_dat_o got %h want 0", bus.wb_dat_o); end
        n_chk++; if (periph[0] !== 32'hFFFF_00FF) begin n_fail++; $display("FAIL full_wr_periph got %h want ffff00ff", periph[0]); end
    endtask

    task automatic test_partial_write();
        run_txn(BASE + 32'h4, 1'b1, 32'h1234_5678, 4'hF, 0);
        run_txn(BASE + 32'h4, 1'b1, 32'hAABB_CCDD, 4'b0101, 0);
        exp_regs[1] = 32'h12BB_56DD;
        n_chk++; if (r_wecyc !== 2 || r_wen !== 1) begin n_fail++; $display("FAIL part_wr_we got cyc %0d n %0d want cyc 2 n 1", r_wecyc, r_wen); end
        n_chk++; if (r_wea !== 2'd1 || r_wed !== 32'h12BB_56DD) begin n_fail++; $display("FAIL part_wr_data got %0d/%h want 1/12bb56dd", r_wea, r_wed); end
        n_chk++; if (r_ack !== 3) begin n_fail++; $display("FAIL part_wr_ack got %0d want 3", r_ack); end
        n_chk++; if (periph[1] !== 32'h12BB_56DD) begin n_fail++; $display("FAIL part_wr_periph got %h want 12bb56dd", periph[1]); end
    endtask

    task automatic test_read();
        run_txn(BASE + 32'h8, 1'b1, 32'hCAFE_F00D, 4'hF, 0);
        exp_regs[2] = 32'hCAFE_F00D;
        run_txn(BASE + 32'h8, 1'b0, 32'h0, 4'hF, 0);
        exp_dato = 32'hCAFE_F00D;
        n_chk++; if (r_wen !== 0) begin n_fail++; $display("FAIL read_no_we got %0d want 0", r_wen); end
        n_chk++; if (r_ack !== 2) begin n_fail++; $display("FAIL read_ack got %0d want 2", r_ack); end
        n_chk++; if (bus.wb_dat_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL read_dat_o got %h want cafef00d", bus.wb_dat_o); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        addrs[0] = BASE + 32'hC; addrs[1] = 32'h2000_0000; addrs[2] = BASE + 32'h2;
        for (int i = 0; i < 3; i++) begin
            run_txn(addrs[i], 1'($urandom), $urandom, 4'hF, 0);
            n_chk++; if (r_err !== 1 || r_ack !== -1) begin
                n_fail++; $display("FAIL err_%0d got err %0d ack %0d want 1/-1", i, r_err, r_ack); end
            n_chk++; if (r_wen !== 0 || bus.wb_dat_o !== exp_dato) begin
                n_fail++; $display("FAIL err_%0d_side got we %0d dat_o %h want 0/%h", i, r_wen, bus.wb_dat_o, exp_dato); end
        end
        run_txn(BASE, 1'b1, 32'h5555_5555, 4'h0, 0);
        n_chk++; if (r_ack !== 1 || r_wen !== 0) begin n_fail++; $display("FAIL sel0_wr got ack %0d we %0d want 1/0", r_ack, r_wen); end
        n_chk++; if (periph[0] !== exp_regs[0]) begin n_fail++; $display("FAIL sel0_periph got %h want %h", periph[0], exp_regs[0]); end
    endtask

    task automatic test_abort();
        int bad;
        bad = 0;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1;
        bus.wb_adr_i = BASE + 32'h4; bus.wb_dat_i = $urandom; bus.wb_sel_i = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        @(posedge clk); #1;
        bus.wb_cyc_i = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (reg_we || bus.wb_ack_o || bus.wb_err_o) bad++;
        end
        bus.wb_cyc_i = 0;
        @(posedge clk); #1;
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL abort_quiet got %0d strobe cycles want 0", bad); end
        n_chk++; if (periph[1] !== exp_regs[1]) begin n_fail++; $display("FAIL abort_periph got %h want %h", periph[1], exp_regs[1]); end
        run_txn(BASE + 32'h4, 1'b0, 32'h0, 4'hF, 0);
        exp_dato = exp_regs[1];
        n_chk++; if (r_ack !== 2 || bus.wb_dat_o !== exp_dato) begin
            n_fail++; $display("FAIL abort_then_read got ack %0d dat %h want 2/%h", r_ack, bus.wb_dat_o, exp_dato); end
    endtask

    task automatic test_back_to_back();
        int unsigned t0;
        logic [31:0] d;
        t0 = cyc_cnt;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            run_txn(BASE + 32'(4 * i), 1'b1, d, 4'hF, i < 2);
            exp_regs[i] = d;
            n_chk++; if (r_wecyc !== 1 || r_ack !== 2 || r_wed !== d) begin
                n_fail++; $display("FAIL b2b_%0d got we %0d ack %0d data %h want 1/2/%h", i, r_wecyc, r_ack, r_wed, d); end
        end
        n_chk++; if (cyc_cnt - t0 !== 9) begin n_fail++; $display("FAIL b2b_cycles got %0d want 9", cyc_cnt - t0); end
    endtask

    task automatic test_random();
        logic [31:0] adr, dat, e_wd;
        logic [3:0]  sel;
        logic        we;
        int          cls, idx, e_ack, e_err, e_we;
        for (int n = 0; n < 80; n++) begin
            cls = $urandom_range(0, 9);
            idx = $urandom_range(0, 3);
            adr = BASE + 32'(4 * idx);
            if (cls == 7) adr = adr + 32'($urandom_range(1, 3));
            if (cls == 8) begin adr = $urandom; if (adr[31:4] == BASE[31:4]) adr[31] = ~adr[31]; end
            case ($urandom_range(0, 3))
                0:       sel = 4'hF;
                1:       sel = 4'h0;
                default: sel = 4'($urandom);
            endcase
            we  = 1'($urandom);
            dat = $urandom;
            model_txn(adr, we, dat, sel, e_ack, e_err, e_we, e_wd);
            run_txn(adr, we, dat, sel, 1'($urandom));
            n_chk++; if (r_ack !== e_ack || r_err !== e_err || r_both) begin
                n_fail++; $display("FAIL rnd_%0d_term adr %h we %b sel %h got ack %0d err %0d both %0d want %0d/%0d",
                                   n, adr, we, sel, r_ack, r_err, r_both, e_ack, e_err); end
            n_chk++; if (r_wecyc !== e_we || r_wen !== ((e_we >= 0) ? 1 : 0)) begin
                n_fail++; $display("FAIL rnd_%0d_we got cyc %0d n %0d want cyc %0d", n, r_wecyc, r_wen, e_we); end
            if (e_we >= 0) begin
                exp_regs[idx] = e_wd;
                n_chk++; if (r_wed !== e_wd || r_wea !== 2'(idx)) begin
                    n_fail++; $display("FAIL rnd_%0d_wdata got %0d/%h want %0d/%h", n, r_wea, r_wed, idx, e_wd); end
            end
            if (e_err < 0 && !we) exp_dato = exp_regs[idx];
            n_chk++; if (bus.wb_dat_o !== exp_dato) begin
                n_fail++; $display("FAIL rnd_%0d_dat_o got %h want %h", n, bus.wb_dat_o, exp_dato); end
            if (idx < NREG) begin
                n_chk++; if (periph[idx] !== exp_regs[idx]) begin
                    n_fail++; $display("FAIL rnd_%0d_periph got %h want %h", n, periph[idx], exp_regs[idx]); end
            end
        end
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1;
        bus.wb_adr_i = BASE + 32'h4; bus.wb_dat_i = ~exp_regs[1]; bus.wb_sel_i = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL rstwr_we got %b want 0", reg_we); end
        @(posedge clk); #1;
        rst = 1'b0; bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        exp_dato = 32'h0;
        n_chk++; if (periph[1] !== exp_regs[1]) begin n_fail++; $display("FAIL rstwr_periph got %h want %h", periph[1], exp_regs[1]); end
        n_chk++; if (bus.wb_dat_o !== 32'h0 || reg_addr !== 2'h0 || reg_wdata !== 32'h0) begin
            n_fail++; $display("FAIL rstwr_regs got %h/%h/%h want 0/0/0", bus.wb_dat_o, reg_addr, reg_wdata); end
        n_chk++; if ({reg_we, bus.wb_ack_o, bus.wb_err_o} !== 3'b000) begin
            n_fail++; $display("FAIL rstwr_strobes got %b want 000", {reg_we, bus.wb_ack_o, bus.wb_err_o}); end
        run_txn(BASE + 32'h8, 1'b0, 32'h0, 4'hF, 0);
        exp_dato = exp_regs[2];
        n_chk++; if (r_ack !== 2 || bus.wb_dat_o !== exp_dato) begin
            n_fail++; $display("FAIL rstwr_read got ack %0d dat %h want 2/%h", r_ack, bus.wb_dat_o, exp_dato); end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_partial_write();
        test_read();
        test_errors();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
